// File: rtl/eth_pkg.sv
// Shared Ethernet tx constants, sender state encoding and length helper.
// Imported by the tx frame sender and its output slot.
package eth_pkg;

  localparam int ETH_HDR_WORDS         = 7;
  localparam int ETH_MIN_PAYLOAD_WORDS = 23;
  localparam int ETH_MAX_PAYLOAD_BYTES = 1500;
  localparam int ETH_LEN_W             = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_DATA,
    S_PAD,
    S_DROP
  } tx_fs_state_t;

  function automatic logic [ETH_LEN_W-1:0] payload_words(
    input logic [ETH_LEN_W-1:0] len
  );
    logic [ETH_LEN_W:0] sum;
    sum = {1'b0, len} + {{ETH_LEN_W{1'b0}}, 1'b1};
    return sum[ETH_LEN_W:1];
  endfunction

endpackage

// File: rtl/eth_word_slot.sv
// One-entry registered output slot for the MAC word interface.
// Loads when empty or being consumed, giving 1 word/clk throughput.
module eth_word_slot
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        ready,
  input  logic [15:0] d_data,
  input  logic        d_sof,
  input  logic        d_eof,
  output logic [15:0] data,
  output logic        sof,
  output logic        eof,
  output logic        valid,
  output logic        can_load
);

  assign can_load = !valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      sof   <= 1'b0;
      eof   <= 1'b0;
      valid <= 1'b0;
    end else if (load && can_load) begin
      data  <= d_data;
      sof   <= d_sof;
      eof   <= d_eof;
      valid <= 1'b1;
    end else if (ready) begin
      sof   <= 1'b0;
      eof   <= 1'b0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_frame_sender.sv
// Drains the tx FIFO into framed MAC words, inserting the source MAC.
// Define TX_FRAME_PAD_EN to zero-pad short frames to the 60-byte minimum.
module tx_frame_sender
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD_WORDS = ETH_MIN_PAYLOAD_WORDS,
  parameter int MAX_PAYLOAD_BYTES = ETH_MAX_PAYLOAD_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_address,
  input  logic        tx_fifo_empty,
  input  logic [15:0] tx_fifo_rd_data,
  output logic        tx_fifo_rd_req,
  output logic [15:0] mac_tx_data,
  output logic        mac_tx_valid,
  output logic        mac_tx_sof,
  output logic        mac_tx_eof,
  input  logic        mac_tx_ready,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic [7:0]  frames_dropped
);

  localparam logic [ETH_LEN_W-1:0] MIN_PW  = ETH_LEN_W'(MIN_PAYLOAD_WORDS);
  localparam logic [ETH_LEN_W-1:0] MAX_LEN = ETH_LEN_W'(MAX_PAYLOAD_BYTES);
  localparam logic [ETH_LEN_W-1:0] ONE     = ETH_LEN_W'(1);
  localparam logic [ETH_LEN_W-1:0] TWO     = ETH_LEN_W'(2);
  localparam logic [ETH_LEN_W:0]   HDR_FIFO_WORDS = (ETH_LEN_W+1)'(4);
  localparam logic [ETH_LEN_W:0]   DROP_ONE       = (ETH_LEN_W+1)'(1);

  tx_fs_state_t state_q, state_d;
  logic [ETH_LEN_W-1:0] pw_q, pw_d;
  logic [ETH_LEN_W-1:0] cnt_q, cnt_d;
  logic [ETH_LEN_W:0]   drop_q, drop_d;
  logic [47:0]          local_q, local_d;

  logic                 pop;
  logic                 load;
  logic                 can_load;
  logic [15:0]          w_data;
  logic                 w_sof;
  logic                 w_eof;
  logic                 drop_done;
  logic                 pad_en;
  logic                 pad_needed;
  logic                 data_last;
  logic [ETH_LEN_W-1:0] len;
  logic [ETH_LEN_W-1:0] pw_new;
  logic                 len_bad;

`ifdef TX_FRAME_PAD_EN
  assign pad_en = 1'b1;
`else
  assign pad_en = 1'b0;
`endif

  assign len        = tx_fifo_rd_data[ETH_LEN_W-1:0];
  assign pw_new     = payload_words(len);
  assign len_bad    = (len == '0) || (len > MAX_LEN);
  assign pad_needed = pad_en && (pw_q < MIN_PW);
  assign data_last  = (cnt_q == pw_q - ONE);

  always_comb begin
    state_d   = state_q;
    pw_d      = pw_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    local_d   = local_q;
    pop       = 1'b0;
    load      = 1'b0;
    w_data    = '0;
    w_sof     = 1'b0;
    w_eof     = 1'b0;
    drop_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!tx_fifo_empty) begin
          pop     = 1'b1;
          pw_d    = pw_new;
          local_d = local_address;
          cnt_d   = '0;
          if (len_bad) begin
            drop_d  = {1'b0, pw_new} + HDR_FIFO_WORDS;
            state_d = S_DROP;
          end else begin
            state_d = S_DST;
          end
        end
      end
      S_DST: begin
        w_data = tx_fifo_rd_data;
        w_sof  = (cnt_q == '0);
        if (can_load && !tx_fifo_empty) begin
          pop  = 1'b1;
          load = 1'b1;
          if (cnt_q == TWO) begin
            cnt_d   = '0;
            state_d = S_SRC;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_SRC: begin
        unique case (cnt_q[1:0])
          2'd0:    w_data = local_q[47:32];
          2'd1:    w_data = local_q[31:16];
          default: w_data = local_q[15:0];
        endcase
        if (can_load) begin
          load = 1'b1;
          if (cnt_q == TWO) begin
            cnt_d   = '0;
            state_d = S_TYPE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_TYPE: begin
        w_data = tx_fifo_rd_data;
        if (can_load && !tx_fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        w_data = tx_fifo_rd_data;
        w_eof  = data_last && !pad_needed;
        if (can_load && !tx_fifo_empty) begin
          pop  = 1'b1;
          load = 1'b1;
          if (data_last) begin
            cnt_d   = '0;
            state_d = pad_needed ? S_PAD : S_IDLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
`ifdef TX_FRAME_PAD_EN
      S_PAD: begin
        w_eof = (cnt_q == MIN_PW - pw_q - ONE);
        if (can_load) begin
          load = 1'b1;
          if (w_eof) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
`endif
      S_DROP: begin
        if (!tx_fifo_empty) begin
          pop    = 1'b1;
          drop_d = drop_q - DROP_ONE;
          if (drop_q == DROP_ONE) begin
            drop_done = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Hold off pops while reset is held so upstream keeps its contents.
  assign tx_fifo_rd_req = pop && !rst;
  assign busy           = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pw_q           <= '0;
      cnt_q          <= '0;
      drop_q         <= '0;
      local_q        <= '0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      local_q <= local_d;
      if (mac_tx_valid && mac_tx_ready && mac_tx_eof)
        frames_sent <= frames_sent + 16'd1;
      if (drop_done && frames_dropped != 8'hFF)
        frames_dropped <= frames_dropped + 8'd1;
    end
  end

  eth_word_slot u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .ready    (mac_tx_ready),
    .d_data   (w_data),
    .d_sof    (w_sof),
    .d_eof    (w_eof),
    .data     (mac_tx_data),
    .sof      (mac_tx_sof),
    .eof      (mac_tx_eof),
    .valid    (mac_tx_valid),
    .can_load (can_load)
  );

endmodule

// File: tb/tb_tx_frame_sender.sv
// Self-checking bench for tx_frame_sender against a frame-level model.
// Honours TX_FRAME_PAD_EN the same way as the design build.
module tb_tx_frame_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] local_address = '0;
  logic        tx_fifo_empty = 1'b1;
  logic [15:0] tx_fifo_rd_data = '0;
  logic        tx_fifo_rd_req;
  logic [15:0] mac_tx_data;
  logic        mac_tx_valid;
  logic        mac_tx_sof;
  logic        mac_tx_eof;
  logic        mac_tx_ready = 1'b1;
  logic        busy;
  logic [15:0] frames_sent;
  logic [7:0]  frames_dropped;

  tx_frame_sender dut (
    .clk            (clk),
    .rst            (rst),
    .local_address  (local_address),
    .tx_fifo_empty  (tx_fifo_empty),
    .tx_fifo_rd_data(tx_fifo_rd_data),
    .tx_fifo_rd_req (tx_fifo_rd_req),
    .mac_tx_data    (mac_tx_data),
    .mac_tx_valid   (mac_tx_valid),
    .mac_tx_sof     (mac_tx_sof),
    .mac_tx_eof     (mac_tx_eof),
    .mac_tx_ready   (mac_tx_ready),
    .busy           (busy),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  logic [15:0] fifo_q[$];
  logic [17:0] got_q[$];
  int          got_cyc[$];
  logic [17:0] exp_q[$];

  bit rdy_rand  = 1'b0;
  bit starve_en = 1'b0;
  int cyc       = 0;
  int n_vec     = 0;
  int n_err     = 0;
  int stab_bad  = 0;
  int nopop_bad = 0;
  int exp_sent  = 0;
  int exp_drop  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model and MAC-side monitor; inputs change 1ns after posedge.
  initial begin
    bit          pend;
    logic        pv, pr, ps, pe;
    logic [15:0] pd;
    pend = 1'b0; pv = 1'b0; pr = 1'b1; ps = 1'b0; pe = 1'b0; pd = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      mac_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_fifo_empty = (fifo_q.size() == 0) || (starve_en && (cyc % 3 == 0));
      tx_fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
      @(negedge clk);
      if (tx_fifo_rd_req && tx_fifo_empty) nopop_bad++;
      if (pv && !pr && !rst &&
          !(mac_tx_valid && mac_tx_data == pd &&
            mac_tx_sof == ps && mac_tx_eof == pe))
        stab_bad++;
      if (mac_tx_valid && mac_tx_ready && !rst) begin
        got_q.push_back({mac_tx_sof, mac_tx_eof, mac_tx_data});
        got_cyc.push_back(cyc);
      end
      pend = tx_fifo_rd_req;
      pv = mac_tx_valid; pr = mac_tx_ready;
      ps = mac_tx_sof;   pe = mac_tx_eof; pd = mac_tx_data;
    end
  end

  // Frame model: what the MAC should see for one FIFO frame.
  task automatic send_frame(input int len);
    logic [15:0] w[$];
    logic [15:0] dst[3];
    logic [15:0] et;
    int          pw;
    pw = (len + 1) / 2;
    for (int i = 0; i < 3; i++) dst[i] = 16'($urandom);
    et = 16'($urandom);
    fifo_q.push_back({5'($urandom), 11'(len)});
    for (int i = 0; i < 3; i++) fifo_q.push_back(dst[i]);
    fifo_q.push_back(et);
    for (int i = 0; i < 3; i++) w.push_back(dst[i]);
    w.push_back(local_address[47:32]);
    w.push_back(local_address[31:16]);
    w.push_back(local_address[15:0]);
    w.push_back(et);
    for (int i = 0; i < pw; i++) begin
      logic [15:0] p;
      p = 16'($urandom);
      fifo_q.push_back(p);
      w.push_back(p);
    end
    if (len >= 1 && len <= 1500) begin
`ifdef TX_FRAME_PAD_EN
      while (w.size() < 30) w.push_back(16'h0000);
`endif
      foreach (w[i])
        exp_q.push_back({i == 0, i == w.size() - 1, w[i]});
      exp_sent = (exp_sent + 1) % 65536;
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while ((got_q.size() < exp_q.size() || fifo_q.size() > 0 || busy)
           && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_timeout"}, 32'(t < 20000), 32'd1);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size())
        chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_sent"}, 32'(frames_sent), exp_sent);
    chk({tag, "_dropped"}, 32'(frames_dropped), exp_drop);
    chk({tag, "_stable"}, stab_bad, 0);
    chk({tag, "_nopop"}, nopop_bad, 0);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(mac_tx_valid), 0);
    chk("rst_sof", 32'(mac_tx_sof), 0);
    chk("rst_eof", 32'(mac_tx_eof), 0);
    chk("rst_data", 32'(mac_tx_data), 0);
    chk("rst_rdreq", 32'(tx_fifo_rd_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sent", 32'(frames_sent), 0);
    chk("rst_drop", 32'(frames_dropped), 0);
    rst = 1'b0;

    local_address = 48'h0200_1122_3344;
    send_frame(100);
    wait_done("l100");
    if (got_cyc.size() >= 57)
      chk("l100_span", got_cyc[56] - got_cyc[0], 56);
    else
      chk("l100_span_short", got_cyc.size(), 57);
    compare_all("l100");

    local_address = 48'hA5A5_0F0F_1234;
    send_frame(10);
    wait_done("l10");
    compare_all("l10");

    send_frame(3);
    send_frame(41);
    wait_done("l3");
    compare_all("l3");

    send_frame(1600);
    send_frame(20);
    wait_done("drop");
    compare_all("drop");

    send_frame(1500);
    send_frame(1501);
    send_frame(1);
    wait_done("bound");
    compare_all("bound");

    rdy_rand  = 1'b1;
    starve_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      local_address = {$urandom, 16'($urandom)};
      send_frame((f == 4) ? 0 : int'($urandom_range(1, 120)));
      wait_done($sformatf("rnd%0d", f));
    end
    compare_all("rnd");
    rdy_rand  = 1'b0;
    starve_en = 1'b0;

    for (int f = 0; f < 260; f++) send_frame(0);
    wait_done("sat");
    compare_all("sat");

    send_frame(200);
    for (int t = 0; t < 2000 && got_q.size() < 30; t++) @(negedge clk);
    chk("mid_reached", 32'(got_q.size() >= 30), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valid", 32'(mac_tx_valid), 0);
    chk("mid_sof", 32'(mac_tx_sof), 0);
    chk("mid_eof", 32'(mac_tx_eof), 0);
    chk("mid_data", 32'(mac_tx_data), 0);
    chk("mid_rdreq", 32'(tx_fifo_rd_req), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_sent", 32'(frames_sent), 0);
    chk("mid_drop", 32'(frames_dropped), 0);
    fifo_q.delete();
    repeat (3) @(negedge clk);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    exp_sent = 0;
    exp_drop = 0;
    rst = 1'b0;
    local_address = 48'h0000_CAFE_BEEF;
    send_frame(46);
    wait_done("fresh");
    compare_all("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
